// File: rtl/cpt_pkg.sv
// Shared constants and helpers for the modulo up/down counter family.
package cpt_pkg;

  typedef enum logic {
    CPT_DIR_DOWN = 1'b0,
    CPT_DIR_UP   = 1'b1
  } cpt_dir_e;

  // Ceiling log2; used only at elaboration to validate counter parameters.
  function automatic int unsigned cpt_clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    if (value > 1) begin
      for (int unsigned i = 0; i < 32; i++) begin
        if (((value - 1) >> i) != 0) result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/cpt_next_value.sv
// Combinational next-count, wrap detection and load clamp for cpt_mod_updown.
module cpt_next_value
  import cpt_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 10
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             up_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_o,
  output logic [WIDTH-1:0] load_clamp_o
);

  // One extra bit so MODULO == 2**WIDTH is representable in the compare.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULO - 1);

  logic [WIDTH:0] inc_ext;

  always_comb begin
    inc_ext      = {1'b0, q_i} + (WIDTH+1)'(1);
    next_o       = q_i;
    wrap_o       = 1'b0;
    load_clamp_o = ({1'b0, load_val_i} < MOD_EXT) ? load_val_i : MAX_Q;
    if (cpt_dir_e'(up_i) == CPT_DIR_UP) begin
      wrap_o = (inc_ext == MOD_EXT);
      next_o = wrap_o ? '0 : inc_ext[WIDTH-1:0];
    end else begin
      wrap_o = (q_i == '0);
      next_o = wrap_o ? MAX_Q : q_i - WIDTH'(1);
    end
  end

endmodule

// File: rtl/cpt_mod_updown.sv
// Modulo-N up/down counter with preset, clamped load, terminal count and wrap pulse.
// Define CPT_MOD_UPDOWN_WRAPCNT_EN to build the saturating WrapCnt event counter.
module cpt_mod_updown
  import cpt_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int MODULO        = 10,
  parameter int WRAPCNT_WIDTH = 8
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             nSet,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             En,
  input  logic             Up,
  output logic [WIDTH-1:0] Q,
  output logic             Tc,
  output logic             Wrap
`ifdef CPT_MOD_UPDOWN_WRAPCNT_EN
  ,
  output logic [WRAPCNT_WIDTH-1:0] WrapCnt
`endif
);

  if (MODULO < 2 || cpt_clog2(MODULO) > WIDTH || WRAPCNT_WIDTH < 1) begin : g_param_check
    $error("cpt_mod_updown: MODULO must lie in 2..2**WIDTH and WRAPCNT_WIDTH >= 1");
  end

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] cnt_next;
  logic             cnt_wrap;
  logic [WIDTH-1:0] load_clamp;

  cpt_next_value #(
    .WIDTH  (WIDTH),
    .MODULO (MODULO)
  ) u_next (
    .q_i          (q_q),
    .up_i         (Up),
    .load_val_i   (LoadVal),
    .next_o       (cnt_next),
    .wrap_o       (cnt_wrap),
    .load_clamp_o (load_clamp)
  );

  // Only the counting branch may raise a wrap; preset and load never do.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (!nSet) begin
      q_d = MAX_Q;
    end else if (Load) begin
      q_d = load_clamp;
    end else if (En) begin
      q_d    = cnt_next;
      wrap_d = cnt_wrap;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign Wrap = wrap_q;
  assign Tc   = En & cnt_wrap;

`ifdef CPT_MOD_UPDOWN_WRAPCNT_EN
  logic [WRAPCNT_WIDTH-1:0] wcnt_q, wcnt_d;

  always_comb begin
    wcnt_d = wcnt_q;
    if (wrap_d && (wcnt_q != '1)) wcnt_d = wcnt_q + WRAPCNT_WIDTH'(1);
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) wcnt_q <= '0;
    else         wcnt_q <= wcnt_d;
  end

  assign WrapCnt = wcnt_q;
`endif

endmodule

// File: tb/tb_cpt_mod_updown.sv
// Directed self-checking bench for cpt_mod_updown (MODULO 10, full-range 16, decade cascade).
module tb_cpt_mod_updown;

  logic       Clk;
  logic       nReset;
  logic       nSet, Load, En, Up;
  logic [3:0] LoadVal;
  logic [3:0] Q;
  logic       Tc, Wrap;

  logic       f_en;
  logic [3:0] f_q;
  logic       f_tc, f_wrap;

  logic       c_en;
  logic [3:0] c_lo_q, c_hi_q;
  logic       c_lo_tc, c_hi_tc, c_lo_wrap, c_hi_wrap;

  int errors = 0;
  int checks = 0;

`ifdef CPT_MOD_UPDOWN_WRAPCNT_EN
  logic [1:0] WrapCnt;
  logic [7:0] f_wcnt, c_lo_wcnt, c_hi_wcnt;
`endif

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  cpt_mod_updown #(.WIDTH(4), .MODULO(10), .WRAPCNT_WIDTH(2)) u_dut (
    .Clk(Clk), .nReset(nReset), .nSet(nSet), .Load(Load), .LoadVal(LoadVal),
    .En(En), .Up(Up), .Q(Q), .Tc(Tc), .Wrap(Wrap)
`ifdef CPT_MOD_UPDOWN_WRAPCNT_EN
    , .WrapCnt(WrapCnt)
`endif
  );

  cpt_mod_updown #(.WIDTH(4), .MODULO(16), .WRAPCNT_WIDTH(8)) u_full (
    .Clk(Clk), .nReset(nReset), .nSet(1'b1), .Load(1'b0), .LoadVal(4'd0),
    .En(f_en), .Up(1'b1), .Q(f_q), .Tc(f_tc), .Wrap(f_wrap)
`ifdef CPT_MOD_UPDOWN_WRAPCNT_EN
    , .WrapCnt(f_wcnt)
`endif
  );

  cpt_mod_updown #(.WIDTH(4), .MODULO(10), .WRAPCNT_WIDTH(8)) u_lo (
    .Clk(Clk), .nReset(nReset), .nSet(1'b1), .Load(1'b0), .LoadVal(4'd0),
    .En(c_en), .Up(1'b1), .Q(c_lo_q), .Tc(c_lo_tc), .Wrap(c_lo_wrap)
`ifdef CPT_MOD_UPDOWN_WRAPCNT_EN
    , .WrapCnt(c_lo_wcnt)
`endif
  );

  cpt_mod_updown #(.WIDTH(4), .MODULO(10), .WRAPCNT_WIDTH(8)) u_hi (
    .Clk(Clk), .nReset(nReset), .nSet(1'b1), .Load(1'b0), .LoadVal(4'd0),
    .En(c_lo_tc), .Up(1'b1), .Q(c_hi_q), .Tc(c_hi_tc), .Wrap(c_hi_wrap)
`ifdef CPT_MOD_UPDOWN_WRAPCNT_EN
    , .WrapCnt(c_hi_wcnt)
`endif
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    nReset = 1'b0; nSet = 1'b1; Load = 1'b0; LoadVal = 4'd0; En = 1'b0; Up = 1'b1;
    f_en = 1'b0; c_en = 1'b0;
    #3;
    checks++; if (Q !== 4'd0) begin errors++; $display("FAIL reset_q got=%0d exp=0", Q); end
    checks++; if (Wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", Wrap); end
    checks++; if (Tc !== 1'b0) begin errors++; $display("FAIL reset_tc got=%b exp=0", Tc); end
    @(negedge Clk);
    nReset = 1'b1;
  endtask

  task automatic test_up_count();
    logic [3:0] exp_q;
    En = 1'b1; Up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_q = 4'(i % 10);
      checks++; if (Q !== exp_q) begin errors++; $display("FAIL up_q[%0d] got=%0d exp=%0d", i, Q, exp_q); end
      checks++; if (Wrap !== (i == 10)) begin errors++; $display("FAIL up_wrap[%0d] got=%b exp=%b", i, Wrap, (i == 10)); end
      checks++; if (Tc !== (exp_q == 4'd9)) begin errors++; $display("FAIL up_tc[%0d] got=%b exp=%b", i, Tc, (exp_q == 4'd9)); end
    end
    En = 1'b0;
  endtask

  task automatic test_down_count();
    Load = 1'b1; LoadVal = 4'd0;
    tick();
    checks++; if (Q !== 4'd0) begin errors++; $display("FAIL dn_load0_q got=%0d exp=0", Q); end
    checks++; if (Wrap !== 1'b0) begin errors++; $display("FAIL dn_load0_wrap got=%b exp=0", Wrap); end
    Load = 1'b0; En = 1'b1; Up = 1'b0;
    #1;
    checks++; if (Tc !== 1'b1) begin errors++; $display("FAIL dn_tc_at0 got=%b exp=1", Tc); end
    tick();
    checks++; if (Q !== 4'd9) begin errors++; $display("FAIL dn_q9 got=%0d exp=9", Q); end
    checks++; if (Wrap !== 1'b1) begin errors++; $display("FAIL dn_wrap got=%b exp=1", Wrap); end
    checks++; if (Tc !== 1'b0) begin errors++; $display("FAIL dn_tc_at9 got=%b exp=0", Tc); end
    tick();
    checks++; if (Q !== 4'd8) begin errors++; $display("FAIL dn_q8 got=%0d exp=8", Q); end
    checks++; if (Wrap !== 1'b0) begin errors++; $display("FAIL dn_wrap8 got=%b exp=0", Wrap); end
    tick();
    checks++; if (Q !== 4'd7) begin errors++; $display("FAIL dn_q7 got=%0d exp=7", Q); end
    // Direction change at the top boundary: 9 counting down gives 8, no wrap.
    Load = 1'b1; LoadVal = 4'd9;
    tick();
    checks++; if (Q !== 4'd9) begin errors++; $display("FAIL dir_load9_q got=%0d exp=9", Q); end
    checks++; if (Wrap !== 1'b0) begin errors++; $display("FAIL dir_load9_wrap got=%b exp=0", Wrap); end
    Load = 1'b0;
    tick();
    checks++; if (Q !== 4'd8) begin errors++; $display("FAIL dir_q8 got=%0d exp=8", Q); end
    checks++; if (Wrap !== 1'b0) begin errors++; $display("FAIL dir_wrap got=%b exp=0", Wrap); end
    En = 1'b0;
  endtask

  task automatic test_priority();
    nSet = 1'b0; Load = 1'b1; LoadVal = 4'd3; En = 1'b1; Up = 1'b0;
    tick();
    checks++; if (Q !== 4'd9) begin errors++; $display("FAIL prio_nset_q got=%0d exp=9", Q); end
    checks++; if (Wrap !== 1'b0) begin errors++; $display("FAIL prio_nset_wrap got=%b exp=0", Wrap); end
    nSet = 1'b1; LoadVal = 4'd12;
    tick();
    checks++; if (Q !== 4'd9) begin errors++; $display("FAIL clamp12_q got=%0d exp=9", Q); end
    checks++; if (Wrap !== 1'b0) begin errors++; $display("FAIL clamp12_wrap got=%b exp=0", Wrap); end
    LoadVal = 4'd5;
    tick();
    checks++; if (Q !== 4'd5) begin errors++; $display("FAIL load5_q got=%0d exp=5", Q); end
    LoadVal = 4'd15;
    tick();
    checks++; if (Q !== 4'd9) begin errors++; $display("FAIL clamp15_q got=%0d exp=9", Q); end
    LoadVal = 4'd0;
    tick();
    checks++; if (Q !== 4'd0) begin errors++; $display("FAIL load0_q got=%0d exp=0", Q); end
    checks++; if (Wrap !== 1'b0) begin errors++; $display("FAIL load0_wrap got=%b exp=0", Wrap); end
    LoadVal = 4'd10;
    tick();
    checks++; if (Q !== 4'd9) begin errors++; $display("FAIL clamp10_q got=%0d exp=9", Q); end
    Load = 1'b0; En = 1'b0; Up = 1'b1;
    #1;
    checks++; if (Tc !== 1'b0) begin errors++; $display("FAIL hold_tc got=%b exp=0", Tc); end
    tick();
    checks++; if (Q !== 4'd9) begin errors++; $display("FAIL hold_q_a got=%0d exp=9", Q); end
    Up = 1'b0;
    tick();
    checks++; if (Q !== 4'd9) begin errors++; $display("FAIL hold_q_b got=%0d exp=9", Q); end
    checks++; if (Wrap !== 1'b0) begin errors++; $display("FAIL hold_wrap got=%b exp=0", Wrap); end
  endtask

  task automatic test_async_reset();
    Load = 1'b1; LoadVal = 4'd7; En = 1'b0;
    tick();
    Load = 1'b0;
    checks++; if (Q !== 4'd7) begin errors++; $display("FAIL ar_pre_q got=%0d exp=7", Q); end
    #3;
    nReset = 1'b0;
    #1;
    checks++; if (Q !== 4'd0) begin errors++; $display("FAIL ar_q got=%0d exp=0", Q); end
    checks++; if (Wrap !== 1'b0) begin errors++; $display("FAIL ar_wrap got=%b exp=0", Wrap); end
    @(negedge Clk);
    nReset = 1'b1;
    // Abort a live wrap pulse between edges.
    Load = 1'b1; LoadVal = 4'd9;
    tick();
    Load = 1'b0; En = 1'b1; Up = 1'b1;
    tick();
    checks++; if (Wrap !== 1'b1) begin errors++; $display("FAIL ar_prewrap got=%b exp=1", Wrap); end
    #2;
    nReset = 1'b0;
    #1;
    checks++; if (Wrap !== 1'b0) begin errors++; $display("FAIL ar_wrap_abort got=%b exp=0", Wrap); end
`ifdef CPT_MOD_UPDOWN_WRAPCNT_EN
    checks++; if (WrapCnt !== 2'd0) begin errors++; $display("FAIL ar_wrapcnt got=%0d exp=0", WrapCnt); end
`endif
    tick();
    checks++; if (Q !== 4'd0) begin errors++; $display("FAIL ar_held_q got=%0d exp=0", Q); end
    @(negedge Clk);
    nReset = 1'b1;
    tick();
    checks++; if (Q !== 4'd1) begin errors++; $display("FAIL ar_first_q got=%0d exp=1", Q); end
    checks++; if (Wrap !== 1'b0) begin errors++; $display("FAIL ar_first_wrap got=%b exp=0", Wrap); end
    En = 1'b0;
  endtask

`ifdef CPT_MOD_UPDOWN_WRAPCNT_EN
  task automatic test_wrapcnt();
    logic [1:0] exp_cnt [5];
    logic [1:0] prev;
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    prev = 2'd0;
    for (int k = 0; k < 5; k++) begin
      Load = 1'b1; LoadVal = 4'd9; En = 1'b0;
      tick();
      checks++; if (WrapCnt !== prev) begin errors++; $display("FAIL wc_load[%0d] got=%0d exp=%0d", k, WrapCnt, prev); end
      Load = 1'b0; En = 1'b1; Up = 1'b1;
      tick();
      checks++; if (WrapCnt !== exp_cnt[k]) begin errors++; $display("FAIL wc_wrap[%0d] got=%0d exp=%0d", k, WrapCnt, exp_cnt[k]); end
      prev = exp_cnt[k];
    end
    En = 1'b0;
  endtask
`endif

  task automatic test_full_range();
    logic [3:0] exp_q;
    f_en = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      exp_q = 4'(i % 16);
      checks++; if (f_q !== exp_q) begin errors++; $display("FAIL full_q[%0d] got=%0d exp=%0d", i, f_q, exp_q); end
      checks++; if (f_wrap !== (i == 16)) begin errors++; $display("FAIL full_wrap[%0d] got=%b exp=%b", i, f_wrap, (i == 16)); end
      checks++; if (f_tc !== (exp_q == 4'd15)) begin errors++; $display("FAIL full_tc[%0d] got=%b exp=%b", i, f_tc, (exp_q == 4'd15)); end
    end
    f_en = 1'b0;
  endtask

  task automatic test_cascade();
    int got;
    c_en = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      got = int'(c_hi_q) * 10 + int'(c_lo_q);
      checks++; if (got !== (i % 100)) begin errors++; $display("FAIL cascade[%0d] got=%0d exp=%0d", i, got, i % 100); end
    end
    checks++; if (c_hi_wrap !== 1'b1) begin errors++; $display("FAIL cascade_hi_wrap got=%b exp=1", c_hi_wrap); end
    c_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_count();
    test_priority();
    test_async_reset();
`ifdef CPT_MOD_UPDOWN_WRAPCNT_EN
    test_wrapcnt();
`endif
    test_full_range();
    test_cascade();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
